// File: rtl/rs_pkg.sv
// Shared constants for the RS(15,11) encoder over GF(16).
// Covers the field polynomial, the generator coefficients, the state
// encoding and a constant-multiply helper.
package rs_pkg;

  localparam int N     = 15;
  localparam int K     = 11;
  localparam int SYM_W = 4;

  // x^4 + x + 1
  localparam logic [4:0] PRIM_POLY = 5'h13;

  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
  localparam logic [SYM_W-1:0] G3 = 4'hD;
  localparam logic [SYM_W-1:0] G2 = 4'hC;
  localparam logic [SYM_W-1:0] G1 = 4'h8;
  localparam logic [SYM_W-1:0] G0 = 4'h7;

  typedef enum logic {
    ST_MSG = 1'b0,
    ST_PAR = 1'b1
  } state_t;

  // Shift-and-add multiply with reduction by the primitive polynomial.
  function automatic logic [SYM_W-1:0] gf16_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] acc;
    logic [SYM_W-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0])
                     : {x[SYM_W-2:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_15_11_encoder_gf16_const_mult.sv
// Combinational GF(16) multiply by a fixed coefficient (one per LFSR tap).
module gf16_const_mult
  import rs_pkg::*;
#(
  parameter logic [SYM_W-1:0] COEF = 4'h1
) (
  input  logic [SYM_W-1:0] a_i,
  output logic [SYM_W-1:0] p_o
);

  assign p_o = gf16_mul(a_i, COEF);

endmodule

// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder with a one-deep valid/ready output register.
// Eleven message symbols pass straight through while the parity LFSR
// accumulates. The four parity symbols are then shifted out.
// Optional build macro RS_ENC_ERR_INJECT_EN adds INJ_EN/INJ_POS/INJ_VAL.
// These XOR a chosen value into one output symbol per codeword; the LFSR
// still sees clean data.
//
// state  | meaning
// ST_MSG | accepting message symbols 0..10, updating the parity LFSR
// ST_PAR | DIN blocked, shifting parity symbols 11..14 out of the LFSR
module rs_15_11_encoder
  import rs_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [SYM_W-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic [SYM_W-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             DOUT_FIRST,
  output logic             DOUT_LAST
`ifdef RS_ENC_ERR_INJECT_EN
  ,
  input  logic             INJ_EN,
  input  logic [SYM_W-1:0] INJ_POS,
  input  logic [SYM_W-1:0] INJ_VAL
`endif
);

  localparam logic [SYM_W-1:0] CNT_LAST_MSG = SYM_W'(K - 1);
  localparam logic [SYM_W-1:0] CNT_LAST_SYM = SYM_W'(N - 1);

  state_t           state_q, state_d;
  logic [SYM_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] p0_q, p1_q, p2_q, p3_q;
  logic [SYM_W-1:0] p0_d, p1_d, p2_d, p3_d;
  logic [SYM_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;

  logic             slot_free;
  logic             accept;
  logic             load;
  logic [SYM_W-1:0] fb;
  logic [SYM_W-1:0] m0, m1, m2, m3;
  logic [SYM_W-1:0] inj_mask;

  assign slot_free = !dout_valid_q || DOUT_READY;
  assign DIN_READY = (state_q == ST_MSG) && slot_free;
  assign accept    = DIN_VALID && DIN_READY;
  assign load      = accept || ((state_q == ST_PAR) && slot_free);
  assign fb        = DIN ^ p3_q;

  gf16_const_mult #(.COEF(G0)) u_mul_g0 (.a_i(fb), .p_o(m0));
  gf16_const_mult #(.COEF(G1)) u_mul_g1 (.a_i(fb), .p_o(m1));
  gf16_const_mult #(.COEF(G2)) u_mul_g2 (.a_i(fb), .p_o(m2));
  gf16_const_mult #(.COEF(G3)) u_mul_g3 (.a_i(fb), .p_o(m3));

`ifdef RS_ENC_ERR_INJECT_EN
  logic             inj_en_q;
  logic [SYM_W-1:0] inj_pos_q, inj_val_q;
  logic             inj_en_eff;
  logic [SYM_W-1:0] inj_pos_eff, inj_val_eff;

  // Symbol 0 uses the live inputs; later symbols use the values captured then.
  assign inj_en_eff  = (cnt_q == '0) ? INJ_EN  : inj_en_q;
  assign inj_pos_eff = (cnt_q == '0) ? INJ_POS : inj_pos_q;
  assign inj_val_eff = (cnt_q == '0) ? INJ_VAL : inj_val_q;
  assign inj_mask    = (inj_en_eff && (inj_pos_eff == cnt_q)) ? inj_val_eff : '0;

  // Capture the injection settings once per codeword, on the symbol 0 load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
      inj_val_q <= '0;
    end else if (load && (cnt_q == '0)) begin
      inj_en_q  <= INJ_EN;
      inj_pos_q <= INJ_POS;
      inj_val_q <= INJ_VAL;
    end
  end
`else
  assign inj_mask = '0;
`endif

  // Next-state: load a message or parity symbol, otherwise drain the slot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p0_d         = p0_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    p3_d         = p3_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    first_d      = first_q;
    last_d       = last_q;

    if (load) begin
      dout_valid_d = 1'b1;
      cnt_d        = cnt_q + 1'b1;
      if (state_q == ST_MSG) begin
        dout_d  = DIN ^ inj_mask;
        first_d = (cnt_q == '0);
        last_d  = 1'b0;
        p3_d    = p2_q ^ m3;
        p2_d    = p1_q ^ m2;
        p1_d    = p0_q ^ m1;
        p0_d    = m0;
        if (cnt_q == CNT_LAST_MSG) state_d = ST_PAR;
      end else begin
        dout_d  = p3_q ^ inj_mask;
        first_d = 1'b0;
        last_d  = (cnt_q == CNT_LAST_SYM);
        p3_d    = p2_q;
        p2_d    = p1_q;
        p1_d    = p0_q;
        p0_d    = '0;
        // The shift already empties the LFSR on the last parity symbol.
        if (cnt_q == CNT_LAST_SYM) begin
          state_d = ST_MSG;
          cnt_d   = '0;
        end
      end
    end else if (dout_valid_q && DOUT_READY) begin
      dout_valid_d = 1'b0;
      first_d      = 1'b0;
      last_d       = 1'b0;
    end
  end

  // State, counter, LFSR and output register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_MSG;
      cnt_q        <= '0;
      p0_q         <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p3_q         <= p3_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign DOUT_FIRST = first_q;
  assign DOUT_LAST  = last_q;

endmodule

// File: tb/tb_rs_15_11_encoder.sv
// Bench for rs_15_11_encoder.
// The reference model does polynomial long division over GF(16) using
// exp/log tables. Inputs change on the falling edge and outputs are sampled
// 1 time unit later.
module tb_rs_15_11_encoder;

  typedef logic [3:0] msg_t [11];
  typedef logic [3:0] cw_t [15];
  typedef struct {
    logic [3:0] d;
    logic       f;
    logic       l;
    int         cyc;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] DIN = 4'h0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [3:0] DOUT;
  logic       DOUT_VALID;
  logic       DOUT_READY = 1'b1;
  logic       DOUT_FIRST;
  logic       DOUT_LAST;
`ifdef RS_ENC_ERR_INJECT_EN
  logic       INJ_EN = 1'b0;
  logic [3:0] INJ_POS = 4'h0;
  logic [3:0] INJ_VAL = 4'h0;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rdy_pct = 100;
  int   gexp [15];
  int   glog [16];
  obs_t obs_q [$];

  rs_15_11_encoder dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIN        (DIN),
    .DIN_VALID  (DIN_VALID),
    .DIN_READY  (DIN_READY),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .DOUT_FIRST (DOUT_FIRST),
    .DOUT_LAST  (DOUT_LAST)
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    .INJ_EN     (INJ_EN),
    .INJ_POS    (INJ_POS),
    .INJ_VAL    (INJ_VAL)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  // Remainder of m(x)*x^4 divided by g(x); index 0 is the highest degree.
  function automatic cw_t encode(input msg_t m);
    int  r [15];
    int  g [5] = '{1, 13, 12, 8, 7};
    int  coef;
    cw_t c;
    for (int i = 0; i < 15; i++) r[i] = (i < 11) ? int'(m[i]) : 0;
    for (int i = 0; i < 11; i++) begin
      coef = r[i];
      if (coef != 0)
        for (int j = 0; j < 5; j++) r[i+j] = r[i+j] ^ gmul(coef, g[j]);
    end
    for (int i = 0; i < 15; i++) c[i] = (i < 11) ? m[i] : 4'(r[i]);
    return c;
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(15));
    return m;
  endfunction

  // Downstream ready pattern.
  initial begin
    forever begin
      @(negedge CLK);
      DOUT_READY = (int'($urandom_range(99)) < rdy_pct);
    end
  end

  // Record output transfers and check that stalled outputs hold steady.
  initial begin
    obs_t       o;
    logic       stall_prev;
    logic [5:0] prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      #1;
      if (RST) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          total++;
          if (DOUT_VALID !== 1'b1 || {DOUT_LAST, DOUT_FIRST, DOUT} !== prev) begin
            bad++;
            $display("FAIL stall_hold got v=%b lfd=%b want v=1 lfd=%b",
                     DOUT_VALID, {DOUT_LAST, DOUT_FIRST, DOUT}, prev);
          end
        end
        if (DOUT_VALID === 1'b1 && DOUT_READY === 1'b1) begin
          o.d = DOUT; o.f = DOUT_FIRST; o.l = DOUT_LAST; o.cyc = cyc;
          obs_q.push_back(o);
        end
        stall_prev = (DOUT_VALID === 1'b1) && (DOUT_READY === 1'b0);
        prev = {DOUT_LAST, DOUT_FIRST, DOUT};
      end
    end
  end

  task automatic send(input msg_t m, input int n, input int vpct);
    int idx = 0;
    for (int c = 0; c < 4000 && idx < n; c++) begin
      @(negedge CLK);
      DIN_VALID = (int'($urandom_range(99)) < vpct);
      DIN = DIN_VALID ? m[idx] : 4'($urandom_range(15));
      #1;
      if (DIN_VALID && DIN_READY) idx++;
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    for (int c = 0; c < 3000 && obs_q.size() < n; c++) @(negedge CLK);
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DIN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    total++; if (DOUT !== 4'h0)       begin bad++; $display("FAIL rst_dout got=%h want=0", DOUT); end
    total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", DOUT_VALID); end
    total++; if (DOUT_FIRST !== 1'b0) begin bad++; $display("FAIL rst_first got=%b want=0", DOUT_FIRST); end
    total++; if (DOUT_LAST !== 1'b0)  begin bad++; $display("FAIL rst_last got=%b want=0", DOUT_LAST); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++; if (DIN_READY !== 1'b1)  begin bad++; $display("FAIL rst_din_ready got=%b want=1", DIN_READY); end
    obs_q.delete();
  endtask

  task automatic test_zero_msg();
    msg_t m;
    obs_t o;
    bit   ok;
    int   c0;
    rdy_pct = 100;
    for (int i = 0; i < 11; i++) m[i] = 4'h0;
    send(m, 11, 100);
    wait_obs(15, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_count got=%0d want=15", obs_q.size()); return; end
    c0 = obs_q[0].cyc;
    for (int i = 0; i < 15; i++) begin
      o = obs_q.pop_front();
      total++;
      if (o.d !== 4'h0 || o.f !== (i == 0) || o.l !== (i == 14) || o.cyc != c0 + i) begin
        bad++;
        $display("FAIL zero_sym%0d got d=%h f=%b l=%b cyc=%0d want d=0 f=%b l=%b cyc=%0d",
                 i, o.d, o.f, o.l, o.cyc, (i == 0), (i == 14), c0 + i);
      end
    end
  endtask

  task automatic test_known_parity();
    msg_t       m;
    obs_t       o;
    bit         ok;
    logic [3:0] par [4] = '{4'hD, 4'hC, 4'h8, 4'h7};
    logic [3:0] want;
    for (int i = 0; i < 11; i++) m[i] = (i == 10) ? 4'h1 : 4'h0;
    send(m, 11, 100);
    wait_obs(15, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL known_count got=%0d want=15", obs_q.size()); return; end
    for (int i = 0; i < 15; i++) begin
      o = obs_q.pop_front();
      want = (i < 11) ? m[i] : par[i-11];
      total++;
      if (o.d !== want || o.f !== (i == 0) || o.l !== (i == 14)) begin
        bad++;
        $display("FAIL known_sym%0d got d=%h f=%b l=%b want d=%h", i, o.d, o.f, o.l, want);
      end
    end
  endtask

  task automatic test_random_stall();
    cw_t  exp_cw [6];
    msg_t m;
    obs_t o;
    bit   ok;
    rdy_pct = 50;
    for (int k = 0; k < 6; k++) begin
      m = rand_msg();
      exp_cw[k] = encode(m);
      send(m, 11, 60);
    end
    wait_obs(90, ok);
    rdy_pct = 100;
    total++;
    if (!ok) begin bad++; $display("FAIL stall_count got=%0d want=90", obs_q.size()); return; end
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 15; i++) begin
        o = obs_q.pop_front();
        total++;
        if (o.d !== exp_cw[k][i] || o.f !== (i == 0) || o.l !== (i == 14)) begin
          bad++;
          $display("FAIL stall_cw%0d_sym%0d got d=%h f=%b l=%b want d=%h",
                   k, i, o.d, o.f, o.l, exp_cw[k][i]);
        end
      end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL stall_extra got=%0d want=0", obs_q.size()); end
  endtask

  task automatic test_mid_reset();
    msg_t m;
    cw_t  e;
    obs_t o;
    bit   ok;
    m = rand_msg();
    send(m, 6, 100);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total++;
    if (DOUT !== 4'h0 || DOUT_VALID !== 1'b0 || DOUT_FIRST !== 1'b0 || DOUT_LAST !== 1'b0) begin
      bad++;
      $display("FAIL midrst_out got d=%h v=%b f=%b l=%b want all 0",
               DOUT, DOUT_VALID, DOUT_FIRST, DOUT_LAST);
    end
    @(negedge CLK);
    RST = 1'b0;
    obs_q.delete();
    m = rand_msg();
    e = encode(m);
    send(m, 11, 100);
    wait_obs(15, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_count got=%0d want=15", obs_q.size()); return; end
    for (int i = 0; i < 15; i++) begin
      o = obs_q.pop_front();
      total++;
      if (o.d !== e[i] || o.f !== (i == 0) || o.l !== (i == 14)) begin
        bad++;
        $display("FAIL midrst_sym%0d got d=%h f=%b l=%b want d=%h", i, o.d, o.f, o.l, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    msg_t m0, m1;
    cw_t  e0, e1;
    obs_t o;
    bit   ok;
    int   c0;
    logic [3:0] want;
    rdy_pct = 100;
    m0 = rand_msg(); m1 = rand_msg();
    e0 = encode(m0); e1 = encode(m1);
    send(m0, 11, 100);
    send(m1, 11, 100);
    wait_obs(30, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_count got=%0d want=30", obs_q.size()); return; end
    c0 = obs_q[0].cyc;
    for (int i = 0; i < 30; i++) begin
      o = obs_q.pop_front();
      want = (i < 15) ? e0[i] : e1[i-15];
      total++;
      if (o.d !== want || o.f !== ((i % 15) == 0) || o.l !== ((i % 15) == 14) || o.cyc != c0 + i) begin
        bad++;
        $display("FAIL b2b_sym%0d got d=%h f=%b l=%b cyc=%0d want d=%h cyc=%0d",
                 i, o.d, o.f, o.l, o.cyc, want, c0 + i);
      end
    end
  endtask

`ifdef RS_ENC_ERR_INJECT_EN
  task automatic test_inject();
    msg_t m;
    cw_t  e;
    obs_t o;
    bit   ok;
    logic [3:0] want;
    m = rand_msg();
    e = encode(m);
    INJ_EN = 1'b1; INJ_POS = 4'd3; INJ_VAL = 4'h5;
    send(m, 11, 100);
    INJ_EN = 1'b0;
    m = rand_msg();
    send(m, 11, 100);
    wait_obs(30, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL inj_count got=%0d want=30", obs_q.size()); return; end
    for (int i = 0; i < 30; i++) begin
      o = obs_q.pop_front();
      if (i < 15) want = (i == 3) ? (e[i] ^ 4'h5) : e[i];
      else begin
        if (i == 15) e = encode(m);
        want = e[i-15];
      end
      total++;
      if (o.d !== want) begin
        bad++;
        $display("FAIL inj_sym%0d got d=%h want d=%h", i, o.d, want);
      end
    end
  endtask
`endif

  initial begin
    gexp[0] = 1;
    glog[0] = 0;
    glog[1] = 0;
    for (int i = 1; i < 15; i++) begin
      int v;
      v = gexp[i-1] << 1;
      if ((v & 16) != 0) v = v ^ 19;
      gexp[i] = v;
      glog[v] = i;
    end

    test_reset();
    test_zero_msg();
    test_known_parity();
    test_random_stall();
    test_mid_reset();
    test_back_to_back();
`ifdef RS_ENC_ERR_INJECT_EN
    test_inject();
`endif
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rs_15_11_encoder.md
RS_15_11_ENCODER -- requirements
Module: rs_15_11_encoder

Interface
REQ-001 SHALL have no parameters; N=15, K=11, SYM_W=4 and generator coefficients are fixed package constants.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port DIN, input, 4, message symbol, highest-degree coefficient first.
REQ-005 SHALL have port DIN_VALID, input, 1, DIN holds a valid symbol.
REQ-006 SHALL have port DIN_READY, output, 1, encoder accepts DIN this cycle.
REQ-007 SHALL have port DOUT, output, 4, codeword symbol (11 message, then 4 parity).
REQ-008 SHALL have port DOUT_VALID, output, 1, DOUT holds a valid symbol.
REQ-009 SHALL have port DOUT_READY, input, 1, downstream accepts DOUT this cycle.
REQ-010 SHALL have ports DOUT_FIRST and DOUT_LAST, output, 1 each, flag codeword symbol 0 and symbol 14.

Function
REQ-011 SHALL compute systematic RS(15,11) over GF(16), primitive polynomial x^4+x+1, g(x)=x^4+0xD x^3+0xC x^2+0x8 x+0x7 (roots alpha^1..alpha^4).
REQ-012 SHALL treat input accept = DIN_VALID & DIN_READY and output transfer = DOUT_VALID & DOUT_READY.
REQ-013 SHALL use a one-deep output register: slot free when !DOUT_VALID | DOUT_READY.
REQ-014 SHALL implement states MSG and PAR; reset to MSG with symbol counter 0.
REQ-015 SHALL drive DIN_READY = (state==MSG) & slot free; DIN_READY SHALL NOT depend combinationally on DIN_VALID.
REQ-016 SHALL, on accept in MSG: DOUT<=DIN, DOUT_VALID<=1, counter+1, LFSR update fb=DIN^P3; P3<=P2^fb*0xD, P2<=P1^fb*0xC, P1<=P0^fb*0x8, P0<=fb*0x7.
REQ-017 SHALL present each accepted message symbol on DOUT one cycle after acceptance (latency 1).
REQ-018 SHALL move MSG->PAR on the 11th accept (counter 10->11).
REQ-019 SHALL, in PAR with slot free: DOUT<=P3, DOUT_VALID<=1, shift P3<=P2, P2<=P1, P1<=P0, P0<=0, counter+1.
REQ-020 SHALL move PAR->MSG, clear counter and LFSR when the 15th symbol is loaded into the output register; the next message may be accepted the following cycle, with no idle gap required.
REQ-021 SHALL hold DOUT, DOUT_FIRST, DOUT_LAST stable while DOUT_VALID & !DOUT_READY.
REQ-022 SHALL clear DOUT_VALID on transfer when no new symbol is loaded in the same cycle.
REQ-023 SHALL assert DOUT_FIRST with symbol index 0 and DOUT_LAST with symbol index 14 only.
REQ-024 SHALL ignore DIN while in PAR (DIN_READY=0); upstream gaps in MSG SHALL leave state and LFSR unchanged.

Reset
REQ-025 SHALL on RST: state=MSG, counter=0, P0..P3=0, DOUT=0, DOUT_VALID=0, DOUT_FIRST=0, DOUT_LAST=0; DIN_READY=1 after release.
REQ-026 SHALL abandon any partial codeword on mid-frame RST; the next accepted symbol starts a fresh codeword.

Configuration
REQ-027 SHALL, with RS_ENC_ERR_INJECT_EN defined, add inputs INJ_EN(1), INJ_POS(4), INJ_VAL(4) sampled per codeword on symbol 0 load; DOUT at index INJ_POS SHALL be XORed with INJ_VAL when INJ_EN was set; LFSR uses uncorrupted data.
REQ-028 SHALL, without RS_ENC_ERR_INJECT_EN, omit those ports and emit uncorrupted codewords.

Structure
REQ-029 SHALL place N, K, SYM_W, PRIM_POLY, generator coefficients G0..G3 and the MSG/PAR state encoding in shared package rs_pkg.
REQ-030 SHALL instantiate sub-module gf16_const_mult (combinational GF(16) multiply by constant) once per LFSR tap.

Verification
REQ-031 All-zero message, DOUT_READY=1 -> 15 zero symbols, FIRST on 1st, LAST on 15th, back-to-back.
REQ-032 Message ten 0x0 then 0x1 -> parity out 0xD,0xC,0x8,0x7.
REQ-033 Random messages, random DIN_VALID/DOUT_READY stalls -> codeword equals model; DOUT stable during stall; no lost or duplicated symbols.
REQ-034 RST asserted after 6th accepted symbol -> outputs zero, next message encodes identically to a fresh start.
REQ-035 Two messages back-to-back, DOUT_READY=1 -> 30 consecutive valid symbols, both parity sets correct.
REQ-036 With RS_ENC_ERR_INJECT_EN, INJ_EN=1, INJ_POS=3, INJ_VAL=0x5 -> only symbol 3 differs from model by XOR 0x5.
